// File: rtl/c7_bist_ctrl_if.sv
// Sequencer/CUT-side signal bundle for c7_bist_ctrl.
// The abort wire exists only when C7_BIST_ABORT_EN is defined.
interface c7_bist_ctrl_if;
    logic       start;
    logic [7:0] pattern_out;
    logic [3:0] response_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] signature;
    logic [7:0] pattern_count;
`ifdef C7_BIST_ABORT_EN
    logic       abort;

    modport master (
        output start, output response_in, output abort,
        input pattern_out, input busy, input done, input pass, input signature,
        input pattern_count
    );
    modport slave (
        input start, input response_in, input abort,
        output pattern_out, output busy, output done, output pass, output signature,
        output pattern_count
    );
`else
    modport master (
        output start, output response_in,
        input pattern_out, input busy, input done, input pass, input signature,
        input pattern_count
    );
    modport slave (
        input start, input response_in,
        output pattern_out, output busy, output done, output pass, output signature,
        output pattern_count
    );
`endif
endinterface

// File: rtl/c7_bist_ctrl.sv
// LFSR-driven BIST controller for the c7 CUT with a 4-bit MISR signature and golden compare.
// Define C7_BIST_ABORT_EN to add the abort input that returns a running test to idle.
module c7_bist_ctrl #(
    parameter int unsigned NUM_PATTERNS  = 255,
    parameter int unsigned SETTLE_CYCLES = 0,
    parameter logic [7:0]  LFSR_SEED     = 8'h01,
    parameter logic [3:0]  GOLDEN_SIG    = 4'h0
) (
    input logic           clk,
    input logic           rst,
    c7_bist_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    // An all-zero seed would lock the LFSR up.
    localparam logic [7:0] SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [7:0] NUM_LAST = NUM_PATTERNS[7:0];
    localparam logic [7:0] SETTLE   = SETTLE_CYCLES[7:0];

    state_t     state;
    logic [7:0] lfsr;
    logic [7:0] hold_cnt;
    logic [7:0] count;
    logic [3:0] misr;
    logic       busy;
    logic       done;
    logic       pass;

    logic [7:0] lfsr_nxt;
    logic [7:0] count_nxt;
    logic [3:0] misr_nxt;
    logic       abort_req;

    always_comb begin
        lfsr_nxt  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        count_nxt = count + 8'd1;
        misr_nxt  = {misr[2] ^ misr[3] ^ bus.response_in[3],
                     misr[1] ^ bus.response_in[2],
                     misr[0] ^ bus.response_in[1],
                     misr[3] ^ bus.response_in[0]};
    end

`ifdef C7_BIST_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            lfsr     <= SEED;
            hold_cnt <= 8'd0;
            count    <= 8'd0;
            misr     <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (bus.start) begin
                        state    <= StRun;
                        lfsr     <= SEED;
                        hold_cnt <= 8'd0;
                        count    <= 8'd0;
                        misr     <= 4'd0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                    end
                end
                StRun: begin
                    if (abort_req) begin
                        // Signature and count stay frozen for post-mortem.
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (hold_cnt != SETTLE) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end else begin
                        misr  <= misr_nxt;
                        count <= count_nxt;
                        if (count_nxt == NUM_LAST) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (misr_nxt == GOLDEN_SIG);
                        end else begin
                            lfsr     <= lfsr_nxt;
                            hold_cnt <= 8'd0;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.pattern_out   = lfsr;
    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.pass          = pass;
    assign bus.signature     = misr;
    assign bus.pattern_count = count;
endmodule
